// File: rtl/i2c_read_arbiter.sv
// Round-robin arbiter sharing one I2C register-read controller among NREQ requesters.
// Grant 1 cycle after request; result 2 cycles after controller done; requesters are held off until done==1.
module i2c_read_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 20000,
  parameter int TW      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [22*NREQ-1:0]   req_cmd,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [7:0]           rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 i2c_start,
  output logic [21:0]          i2c_cmd,
  input  logic                 i2c_done,
  input  logic                 i2c_ack,
  input  logic [7:0]           i2c_rdata
);

  localparam int OW = $clog2(NREQ);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [OW-1:0] owner;
  logic [OW-1:0] last;
  logic [OW-1:0] win;
  logic [OW-1:0] idx;
  logic          found;
  logic [TW-1:0] timer;
  logic          timed_out;

  // Scan from last+1 upward, wrapping, so the previous owner is considered last.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = OW'((int'(last) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign timed_out = (timer == TMAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      owner     <= '0;
      last      <= OW'(NREQ - 1);
      timer     <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_data  <= 8'h00;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      i2c_start <= 1'b0;
      i2c_cmd   <= 22'h0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          if (i2c_done && found) begin
            owner          <= win;
            i2c_cmd        <= req_cmd[22*int'(win) +: 22];
            req_ready[win] <= 1'b1;
            timer          <= '0;
            busy           <= 1'b1;
            i2c_start      <= 1'b1;
            state          <= ST_START;
          end
        end
        ST_START: begin
          timer <= timer + 1'b1;
          // done going low is the controller's acknowledgement of the start
          if (!i2c_done) begin
            i2c_start <= 1'b0;
            state     <= ST_WAIT;
          end else if (timed_out) begin
            i2c_start <= 1'b0;
            rsp_data  <= 8'h00;
            rsp_err   <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_WAIT: begin
          timer <= timer + 1'b1;
          if (i2c_done) begin
            rsp_data <= i2c_rdata;
            rsp_err  <= !i2c_ack;
            state    <= ST_RESP;
          end else if (timed_out) begin
            i2c_start <= 1'b0;
            rsp_data  <= 8'h00;
            rsp_err   <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          rsp_valid[owner] <= 1'b1;
          last             <= owner;
          state            <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_read_arbiter.sv
// Directed bench for i2c_read_arbiter with a small I2C controller model driving done/ack/rdata.
module tb_i2c_read_arbiter;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 50;
  localparam int TW      = 16;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [43:0] req_cmd;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        i2c_start;
  logic [21:0] i2c_cmd;
  logic        i2c_done;
  logic        i2c_ack;
  logic [7:0]  i2c_rdata;

  int checks = 0;
  int errors = 0;

  logic       mdl_respond  = 1'b0;
  logic       mdl_hold_low = 1'b0;
  logic       mdl_ack      = 1'b1;
  logic [7:0] mdl_rdata    = 8'h00;
  int         mdl_len      = 40;
  int         mdl_starts   = 0;

  i2c_read_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_cmd   (req_cmd),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .i2c_start (i2c_start),
    .i2c_cmd   (i2c_cmd),
    .i2c_done  (i2c_done),
    .i2c_ack   (i2c_ack),
    .i2c_rdata (i2c_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Controller: drops done for mdl_len cycles after seeing a start, then returns data.
  initial begin
    i2c_done  = 1'b1;
    i2c_ack   = 1'b0;
    i2c_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (mdl_hold_low) begin
        i2c_done = 1'b0;
      end else if (mdl_respond && i2c_start && i2c_done) begin
        i2c_done = 1'b0;
        mdl_starts++;
        repeat (mdl_len) @(posedge clk);
        #1;
        i2c_rdata = mdl_rdata;
        i2c_ack   = mdl_ack;
        i2c_done  = 1'b1;
      end else begin
        i2c_done = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int s0;
    logic [1:0] exp_oh;

    reset     = 1'b1;
    req_valid = 2'b00;
    req_cmd   = 44'h0;
    repeat (3) tick();
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_data",  32'(rsp_data),  32'h0);
    check("rst_rsp_err",   32'(rsp_err),   32'h0);
    check("rst_busy",      32'(busy),      32'h0);
    check("rst_i2c_start", 32'(i2c_start), 32'h0);
    check("rst_i2c_cmd",   32'(i2c_cmd),   32'h0);
    reset = 1'b0;
    tick();

    // Single read by requester 0
    req_cmd     = {22'h123456, 22'h0A5D2E};
    mdl_respond = 1'b1;
    mdl_len     = 40;
    mdl_rdata   = 8'hA5;
    mdl_ack     = 1'b1;
    req_valid   = 2'b01;
    tick();
    check("rd_req_ready", 32'(req_ready), 32'h1);
    check("rd_busy",      32'(busy),      32'h1);
    check("rd_start",     32'(i2c_start), 32'h1);
    check("rd_cmd",       32'(i2c_cmd),   32'h0A5D2E);
    req_valid = 2'b00;
    req_cmd   = {22'h123456, 22'h3FFFFF};
    tick();
    check("rd_ready_pulse", 32'(req_ready), 32'h0);
    check("rd_start_drop",  32'(i2c_start), 32'h0);
    n = 0;
    while (rsp_valid == 2'b00 && n < 200) begin tick(); n++; end
    check("rd_latency",  32'(n),         32'd41);
    check("rd_rsp_vld",  32'(rsp_valid), 32'h1);
    check("rd_rsp_data", 32'(rsp_data),  32'hA5);
    check("rd_rsp_err",  32'(rsp_err),   32'h0);
    check("rd_cmd_held", 32'(i2c_cmd),   32'h0A5D2E);
    check("rd_busy_rsp", 32'(busy),      32'h1);
    tick();
    check("rd_rsp_pulse", 32'(rsp_valid), 32'h0);
    check("rd_busy_fall", 32'(busy),      32'h0);
    check("rd_data_hold", 32'(rsp_data),  32'hA5);

    // NACK read by requester 1
    req_cmd   = {22'h2ABCDE, 22'h111111};
    mdl_len   = 10;
    mdl_rdata = 8'h3C;
    mdl_ack   = 1'b0;
    req_valid = 2'b10;
    tick();
    check("nack_req_ready", 32'(req_ready), 32'h2);
    check("nack_cmd",       32'(i2c_cmd),   32'h2ABCDE);
    req_valid = 2'b00;
    n = 0;
    while (rsp_valid == 2'b00 && n < 200) begin tick(); n++; end
    check("nack_rsp_vld",  32'(rsp_valid), 32'h2);
    check("nack_rsp_err",  32'(rsp_err),   32'h1);
    check("nack_rsp_data", 32'(rsp_data),  32'h3C);

    // Contention: both requesting continuously, alternate starting at 0
    mdl_len   = 5;
    mdl_rdata = 8'h77;
    mdl_ack   = 1'b1;
    s0        = mdl_starts;
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (req_ready == 2'b00 && n < 50) begin tick(); n++; end
      check("arb_gap", 32'(n), 32'd1);
      exp_oh = (g % 2 == 0) ? 2'b01 : 2'b10;
      check("arb_grant", 32'(req_ready), 32'(exp_oh));
      check("arb_cmd", 32'(i2c_cmd), (g % 2 == 0) ? 32'h111111 : 32'h2ABCDE);
      n = 0;
      while (rsp_valid == 2'b00 && n < 100) begin tick(); n++; end
      check("arb_rsp", 32'(rsp_valid), 32'(exp_oh));
      if (g == 3) req_valid = 2'b00;
    end
    check("arb_starts", 32'(mdl_starts - s0), 32'd4);

    // Timeout: controller never acknowledges the start
    mdl_respond = 1'b0;
    req_valid   = 2'b01;
    tick();
    check("to_req_ready", 32'(req_ready), 32'h1);
    req_valid = 2'b00;
    n = 0;
    while (i2c_start && n < 200) begin tick(); n++; end
    check("to_start_cycles", 32'(n), 32'd50);
    check("to_no_rsp_yet", 32'(rsp_valid), 32'h0);
    tick();
    check("to_rsp_vld",  32'(rsp_valid), 32'h1);
    check("to_rsp_err",  32'(rsp_err),   32'h1);
    check("to_rsp_data", 32'(rsp_data),  32'h00);

    // Controller still busy after the timeout: no grant until done returns
    mdl_hold_low = 1'b1;
    tick();
    req_valid = 2'b01;
    n = 0;
    repeat (10) begin tick(); if (req_ready != 2'b00) n++; end
    check("hold_no_grant", 32'(n), 32'd0);
    mdl_hold_low = 1'b0;
    mdl_respond  = 1'b1;
    mdl_len      = 5;
    mdl_rdata    = 8'h5A;
    n = 0;
    while (req_ready == 2'b00 && n < 20) begin tick(); n++; end
    check("hold_grant", 32'(req_ready), 32'h1);
    req_valid = 2'b00;
    n = 0;
    while (rsp_valid == 2'b00 && n < 100) begin tick(); n++; end
    check("hold_rsp_vld",  32'(rsp_valid), 32'h1);
    check("hold_rsp_data", 32'(rsp_data),  32'h5A);
    check("hold_rsp_err",  32'(rsp_err),   32'h0);

    // Reset in the middle of a requester-1 read
    mdl_len   = 40;
    req_valid = 2'b10;
    tick();
    check("mid_req_ready", 32'(req_ready), 32'h2);
    req_valid = 2'b00;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_req_ready", 32'(req_ready), 32'h0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("mid_rst_rsp_data",  32'(rsp_data),  32'h0);
    check("mid_rst_rsp_err",   32'(rsp_err),   32'h0);
    check("mid_rst_busy",      32'(busy),      32'h0);
    check("mid_rst_start",     32'(i2c_start), 32'h0);
    check("mid_rst_cmd",       32'(i2c_cmd),   32'h0);
    n = 0;
    repeat (60) begin tick(); if (rsp_valid != 2'b00) n++; end
    check("mid_no_rsp", 32'(n), 32'd0);
    mdl_len   = 5;
    req_valid = 2'b11;
    n = 0;
    while (req_ready == 2'b00 && n < 20) begin tick(); n++; end
    check("post_rst_grant", 32'(req_ready), 32'h1);
    req_valid = 2'b00;
    n = 0;
    while (rsp_valid == 2'b00 && n < 100) begin tick(); n++; end
    check("post_rst_rsp", 32'(rsp_valid), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
